// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter granting one shared memory port to 4 requesters; grants held until release.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module mem_port_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int CNT_BITS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       rel,
    output logic [3:0] grant,
    output logic [1:0] mux_select,
    output logic       busy,
    output logic       expire
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t              state_reg, state_next;
    logic [3:0]          grant_reg, grant_next;
    logic [1:0]          owner_reg, owner_next;
    logic [1:0]          last_owner_reg, last_owner_next;
    logic [CNT_BITS-1:0] hold_cnt_reg, hold_cnt_next;

    logic [3:0] arb_req;
    logic [1:0] arb_base;
    logic [1:0] win_idx;
    logic [3:0] win_onehot;
    logic       release_now;
    logic       hold_at_max;
    logic       timeout;
    logic       expire_c;

    // First set bit scanning base+1 .. base+4; base itself ends up lowest priority.
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] idx;
        rr_pick = base;
        for (int i = 4; i >= 1; i--) begin
            idx = base + 2'(i);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    assign release_now = (state_reg == GRANT) && (rel || !req[owner_reg]);
    assign hold_at_max = (hold_cnt_reg == CNT_BITS'(MAX_HOLD - 1));

`ifdef ARB_TIMEOUT_EN
    assign timeout = (state_reg == GRANT) && hold_at_max && !release_now;
`else
    assign timeout = 1'b0;
`endif

    // On a voluntary release the owner is excluded so it cannot immediately win again.
    always_comb begin
        arb_req  = req;
        arb_base = last_owner_reg;
        if (state_reg == GRANT) begin
            arb_base = owner_reg;
            if (release_now) arb_req = req & ~grant_reg;
        end
    end

    assign win_idx = rr_pick(arb_req, arb_base);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_idx == 2'(gi));
        end
    endgenerate

    always_comb begin
        state_next      = state_reg;
        grant_next      = grant_reg;
        owner_next      = owner_reg;
        last_owner_next = last_owner_reg;
        hold_cnt_next   = hold_cnt_reg;
        expire_c        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (|req) begin
                    state_next    = GRANT;
                    grant_next    = win_onehot;
                    owner_next    = win_idx;
                    hold_cnt_next = '0;
                end
            end
            GRANT: begin
                if (release_now) begin
                    last_owner_next = owner_reg;
                    if (|arb_req) begin
                        grant_next    = win_onehot;
                        owner_next    = win_idx;
                        hold_cnt_next = '0;
                    end else begin
                        state_next = IDLE;
                        grant_next = 4'b0000;
                    end
                end else if (timeout) begin
                    // Owner still requests, so a sole requester simply wins again.
                    expire_c        = 1'b1;
                    last_owner_next = owner_reg;
                    grant_next      = win_onehot;
                    owner_next      = win_idx;
                    hold_cnt_next   = '0;
                end else if (!hold_at_max) begin
                    hold_cnt_next = hold_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            grant_reg      <= 4'b0000;
            owner_reg      <= 2'd0;
            last_owner_reg <= 2'd3;
            hold_cnt_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            grant_reg      <= grant_next;
            owner_reg      <= owner_next;
            last_owner_reg <= last_owner_next;
            hold_cnt_reg   <= hold_cnt_next;
        end
    end

    assign grant      = grant_reg;
    assign mux_select = owner_reg;
    assign busy       = (state_reg == GRANT);
    assign expire     = expire_c;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter; covers the timeout scenario when ARB_TIMEOUT_EN is defined.
module tb_mem_port_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req = 4'b0000;
    logic       rel = 1'b0;
    logic [3:0] grant;
    logic [1:0] mux_select;
    logic       busy;
    logic       expire;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.MAX_HOLD(8), .CNT_BITS(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .rel        (rel),
        .grant      (grant),
        .mux_select (mux_select),
        .busy       (busy),
        .expire     (expire)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end else begin
            $display("ok   %s: %0h", tag, act);
        end
    endtask

    task automatic check_state(input string tag, input logic [3:0] g, input logic [1:0] s,
                               input logic b);
        check_eq({tag, ".grant"}, 32'(grant), 32'(g));
        check_eq({tag, ".sel"},   32'(mux_select), 32'(s));
        check_eq({tag, ".busy"},  32'(busy), 32'(b));
    endtask

    logic [3:0] rr_exp [4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] rr_sel [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        // reset state
        rst = 1'b1; req = 4'b0000; rel = 1'b0;
        tick(); tick();
        check_state("reset", 4'b0000, 2'd0, 1'b0);
        check_eq("reset.expire", 32'(expire), 32'd0);

        // first grant after reset goes to requester 0
        rst = 1'b0; req = 4'b1111;
        tick();
        check_state("t1", 4'b0001, 2'd0, 1'b1);

        // back-to-back rotation with rel each cycle
        rel = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check_state($sformatf("t2.rr%0d", i), rr_exp[i], rr_sel[i], 1'b1);
        end

        // hand to owner 2, hold, non-owner toggling has no effect
        req = 4'b0100; rel = 1'b1;
        tick();
        check_state("t3.to2", 4'b0100, 2'd2, 1'b1);
        rel = 1'b0;
        tick();
        check_state("t3.hold", 4'b0100, 2'd2, 1'b1);
        req = 4'b0111;
        tick();
        req = 4'b1101;
        tick();
        check_state("t3.toggle", 4'b0100, 2'd2, 1'b1);

        // owner drops request with nobody else -> idle, sel holds 2
        req = 4'b0000;
        tick();
        check_state("t3.idle", 4'b0000, 2'd2, 1'b0);
        tick();
        check_state("t3.idle2", 4'b0000, 2'd2, 1'b0);
        req = 4'b0001;
        tick();
        check_state("t3.regrant", 4'b0001, 2'd0, 1'b1);

        // rel and req drop together -> single release, last_owner=0
        rel = 1'b1; req = 4'b0000;
        tick();
        check_state("t6.idle", 4'b0000, 2'd0, 1'b0);
        rel = 1'b0; req = 4'b1111;
        tick();
        check_state("t6.next", 4'b0010, 2'd1, 1'b1);

        // reset mid-grant
        rel = 1'b1;
        tick();
        check_state("t4.pre", 4'b0100, 2'd2, 1'b1);
        rel = 1'b0; rst = 1'b1;
        tick();
        check_state("t4.rst", 4'b0000, 2'd0, 1'b0);
        rst = 1'b0; req = 4'b1111;
        tick();
        check_state("t4.after", 4'b0001, 2'd0, 1'b1);

`ifdef ARB_TIMEOUT_EN
        // forced release after 8 cycles, then sole requester regranted
        rst = 1'b1; req = 4'b0000;
        tick();
        rst = 1'b0; req = 4'b0011;
        tick();
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t5.g0.c%0d", i), 32'(grant), 32'h1);
            check_eq($sformatf("t5.exp0.c%0d", i), 32'(expire), (i == 7) ? 32'd1 : 32'd0);
            tick();
        end
        check_state("t5.to1", 4'b0010, 2'd1, 1'b1);
        req = 4'b0001;
        tick();
        check_state("t5.back0", 4'b0001, 2'd0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t5.g1.c%0d", i), 32'(grant), 32'h1);
            check_eq($sformatf("t5.exp1.c%0d", i), 32'(expire), (i == 7) ? 32'd1 : 32'd0);
            tick();
        end
        check_state("t5.regrant", 4'b0001, 2'd0, 1'b1);
        check_eq("t5.exp.after", 32'(expire), 32'd0);
`else
        // without timeout a grant is held indefinitely and expire stays low
        for (int i = 0; i < 20; i++) begin
            tick();
            check_eq($sformatf("hold.g.c%0d", i), 32'(grant), 32'h1);
            check_eq($sformatf("hold.exp.c%0d", i), 32'(expire), 32'd0);
        end
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
